// File: rtl/cache_mem_arbiter_pkg.sv
// cache_mem_arbiter_pkg: shared FSM state, grant and size constants for the cache/memory arbiter
package cache_mem_arbiter_pkg;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ADDR   = 2'd1;
    localparam logic [1:0] ST_DATA   = 2'd2;
    localparam logic       GNT_I     = 1'b0;
    localparam logic       GNT_D     = 1'b1;
    localparam logic [1:0] SIZE_WORD = 2'd2;
endpackage

// File: rtl/cache_mem_arb_pick.sv
// cache_mem_arb_pick: Dcache-priority pick with Icache anti-starvation; in icache_req/dcache_req/starve_cnt, out gnt_valid/gnt/starve_cnt_nxt
module cache_mem_arb_pick
    import cache_mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_WIDTH    = 3
) (
    input  logic                 icache_req,
    input  logic                 dcache_req,
    input  logic [CNT_WIDTH-1:0] starve_cnt,
    output logic                 gnt_valid,
    output logic                 gnt,
    output logic [CNT_WIDTH-1:0] starve_cnt_nxt
);
    localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(STARVE_LIMIT);
    always_comb begin
        gnt_valid      = icache_req | dcache_req;
        gnt            = (dcache_req && !(icache_req && starve_cnt == LIMIT)) ? GNT_D : GNT_I;
        // only a Dcache win over a waiting Icache counts toward starvation
        starve_cnt_nxt = (gnt == GNT_D && icache_req) ?
                         ((starve_cnt == LIMIT) ? starve_cnt : starve_cnt + 1'b1) : '0;
    end
endmodule

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one memory req/addrOK/dataOK port between Icache (line reads) and Dcache; clk/rst, icache_*/mem_icache_*, dcache_*/mem_dcache_*, mem_* ports
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int OFFSET_WIDTH = 2,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_WIDTH    = 3,
    localparam int LW          = 32 * (1 << OFFSET_WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          icache_mem_req,
    input  logic [31:0]   icache_mem_addr,
    output logic          mem_icache_addrOK,
    output logic          mem_icache_dataOK,
    output logic [LW-1:0] mem_icache_din,
    input  logic          dcache_mem_req,
    input  logic          dcache_mem_wr,
    input  logic          dcache_mem_SUC,
    input  logic [31:0]   dcache_mem_addr,
    input  logic [31:0]   dcache_mem_dout,
    input  logic [1:0]    dcache_mem_size,
    input  logic [3:0]    dcache_mem_wstrb,
    output logic          mem_dcache_addrOK,
    output logic          mem_dcache_dataOK,
    output logic [LW-1:0] mem_dcache_din,
    output logic          mem_req,
    output logic          mem_wr,
    output logic          mem_SUC,
    output logic          mem_line,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [1:0]    mem_size,
    output logic [3:0]    mem_wstrb,
    input  logic          mem_addrOK,
    input  logic          mem_dataOK,
    input  logic [LW-1:0] mem_rdata
);
    logic [1:0]           state_q, state_d;
    logic                 grant_q, grant_d;
    logic [CNT_WIDTH-1:0] starve_q, starve_d;
    logic                 pick_valid, pick_gnt;
    logic [CNT_WIDTH-1:0] pick_cnt;
    logic                 is_d, greq, in_addr, in_data, act, aok, dok;

    cache_mem_arb_pick #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_WIDTH(CNT_WIDTH)) u_pick (
        .icache_req     (icache_mem_req),
        .dcache_req     (dcache_mem_req),
        .starve_cnt     (starve_q),
        .gnt_valid      (pick_valid),
        .gnt            (pick_gnt),
        .starve_cnt_nxt (pick_cnt)
    );

    always_comb begin
        is_d     = grant_q == GNT_D;
        greq     = is_d ? dcache_mem_req : icache_mem_req;
        in_addr  = state_q == ST_ADDR;
        in_data  = state_q == ST_DATA;
        act      = in_addr && greq;
        aok      = act && mem_addrOK;
        // a dataOK only counts once the address has been accepted (possibly this same cycle)
        dok      = (in_data || aok) && mem_dataOK;
        state_d  = state_q;
        grant_d  = grant_q;
        starve_d = starve_q;
        if (state_q == ST_IDLE) begin
            if (pick_valid) begin
                state_d  = ST_ADDR;
                grant_d  = pick_gnt;
                starve_d = pick_cnt;
            end
        end else if (in_addr) begin
            state_d = !greq ? ST_IDLE : !mem_addrOK ? ST_ADDR : mem_dataOK ? ST_IDLE : ST_DATA;
        end else begin
            state_d = (in_data && !mem_dataOK) ? ST_DATA : ST_IDLE;
        end
        mem_req           = act;
        mem_wr            = act && is_d && dcache_mem_wr;
        mem_SUC           = act && is_d && dcache_mem_SUC;
        mem_line          = act && (!is_d || (!dcache_mem_wr && !dcache_mem_SUC));
        mem_addr          = act ? (is_d ? dcache_mem_addr : icache_mem_addr) : '0;
        mem_wdata         = (act && is_d) ? dcache_mem_dout : '0;
        mem_size          = act ? (is_d ? dcache_mem_size : SIZE_WORD) : '0;
        mem_wstrb         = (act && is_d) ? dcache_mem_wstrb : '0;
        mem_icache_addrOK = aok && !is_d;
        mem_dcache_addrOK = aok && is_d;
        mem_icache_dataOK = dok && !is_d;
        mem_dcache_dataOK = dok && is_d;
        mem_icache_din    = (dok && !is_d) ? mem_rdata : '0;
        mem_dcache_din    = (dok && is_d) ? mem_rdata : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= GNT_I;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            starve_q <= starve_d;
        end
    end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: directed scenarios plus randomized traffic checked against a transaction-level model
module tb_cache_mem_arbiter;
    localparam int OW = 2;
    localparam int LW = 32 * (1 << OW);
    localparam int LIM = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          i_req, d_req, d_wr, d_suc, m_aok_in, m_dok_in;
    logic [31:0]   i_addr, d_addr, d_dout;
    logic [1:0]    d_size;
    logic [3:0]    d_wstrb;
    logic [LW-1:0] m_rdata;
    logic          mem_icache_addrOK, mem_icache_dataOK, mem_dcache_addrOK, mem_dcache_dataOK;
    logic [LW-1:0] mem_icache_din, mem_dcache_din;
    logic          mem_req, mem_wr, mem_SUC, mem_line;
    logic [31:0]   mem_addr, mem_wdata;
    logic [1:0]    mem_size;
    logic [3:0]    mem_wstrb;

    cache_mem_arbiter #(.OFFSET_WIDTH(OW), .STARVE_LIMIT(LIM), .CNT_WIDTH(3)) dut (
        .clk(clk), .rst(rst),
        .icache_mem_req(i_req), .icache_mem_addr(i_addr),
        .mem_icache_addrOK(mem_icache_addrOK), .mem_icache_dataOK(mem_icache_dataOK),
        .mem_icache_din(mem_icache_din),
        .dcache_mem_req(d_req), .dcache_mem_wr(d_wr), .dcache_mem_SUC(d_suc),
        .dcache_mem_addr(d_addr), .dcache_mem_dout(d_dout), .dcache_mem_size(d_size),
        .dcache_mem_wstrb(d_wstrb),
        .mem_dcache_addrOK(mem_dcache_addrOK), .mem_dcache_dataOK(mem_dcache_dataOK),
        .mem_dcache_din(mem_dcache_din),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_SUC(mem_SUC), .mem_line(mem_line),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addrOK(m_aok_in), .mem_dataOK(m_dok_in), .mem_rdata(m_rdata)
    );

    int vectors = 0;
    int miscompares = 0;
    int i_dok_n = 0;
    int d_dok_n = 0;

    // transaction-level model: who owns the port, whether its address was taken, starvation tally
    logic m_busy, m_own, m_acc;
    int   m_cnt;
    logic e_i_aok, e_d_aok, e_i_dok, e_d_dok;

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic zero_chk(input string nm);
        chk({nm, "_ctl"}, {mem_req, mem_wr, mem_SUC, mem_line, mem_addr, mem_wdata, mem_size,
            mem_wstrb, mem_icache_addrOK, mem_icache_dataOK, mem_dcache_addrOK, mem_dcache_dataOK}, '0);
        chk({nm, "_idin"}, mem_icache_din, '0);
        chk({nm, "_ddin"}, mem_dcache_din, '0);
    endtask

    task automatic check();
        logic greq, in_addr, in_data, e_req, e_aok, e_dok;
        if (rst) begin
            m_busy = 1'b0;
            m_acc = 1'b0;
            m_cnt = 0;
        end
        in_addr = m_busy && !m_acc;
        in_data = m_busy && m_acc;
        greq = m_own ? d_req : i_req;
        e_req = in_addr && greq;
        e_aok = e_req && m_aok_in;
        e_dok = (in_data || e_aok) && m_dok_in;
        e_i_aok = e_aok && !m_own;
        e_d_aok = e_aok && m_own;
        e_i_dok = e_dok && !m_own;
        e_d_dok = e_dok && m_own;
        chk("mem_req", mem_req, e_req);
        chk("icache_addrOK", mem_icache_addrOK, e_i_aok);
        chk("dcache_addrOK", mem_dcache_addrOK, e_d_aok);
        chk("icache_dataOK", mem_icache_dataOK, e_i_dok);
        chk("dcache_dataOK", mem_dcache_dataOK, e_d_dok);
        if (e_i_dok) chk("icache_din", mem_icache_din, m_rdata);
        if (e_d_dok) chk("dcache_din", mem_dcache_din, m_rdata);
        if (m_busy && m_own) chk("icache_din_ungranted", mem_icache_din, '0);
        if (m_busy && !m_own) chk("dcache_din_ungranted", mem_dcache_din, '0);
        if (e_req && !m_own) begin
            chk("i_fields", {mem_wr, mem_SUC, mem_line, mem_addr, mem_wdata, mem_size, mem_wstrb},
                {1'b0, 1'b0, 1'b1, i_addr, 32'h0, 2'd2, 4'h0});
        end
        if (e_req && m_own) begin
            chk("d_fields", {mem_wr, mem_SUC, mem_line, mem_addr, mem_wdata, mem_size, mem_wstrb},
                {d_wr, d_suc, !d_wr && !d_suc, d_addr, d_dout, d_size, d_wstrb});
        end
        chk("state", dut.state_q, m_busy ? (m_acc ? 2 : 1) : 0);
        chk("starve_cnt", dut.starve_q, m_cnt);
        i_dok_n += int'(mem_icache_dataOK);
        d_dok_n += int'(mem_dcache_dataOK);
    endtask

    task automatic update_model();
        logic greq;
        greq = m_own ? d_req : i_req;
        if (rst) begin
            m_busy = 1'b0;
            m_acc = 1'b0;
            m_cnt = 0;
        end else if (!m_busy) begin
            if (i_req || d_req) begin
                m_own = d_req && !(i_req && m_cnt == LIM);
                m_cnt = (m_own && i_req) ? ((m_cnt < LIM) ? m_cnt + 1 : LIM) : 0;
                m_busy = 1'b1;
                m_acc = 1'b0;
            end
        end else if (!m_acc) begin
            if (!greq) m_busy = 1'b0;
            else if (m_aok_in) begin
                if (m_dok_in) m_busy = 1'b0;
                else m_acc = 1'b1;
            end
        end else if (m_dok_in) begin
            m_busy = 1'b0;
            m_acc = 1'b0;
        end
    endtask

    task automatic step();
        #1 check();
        @(posedge clk);
        update_model();
        @(negedge clk);
    endtask

    initial begin
        logic [4:0] seq;
        logic [LW-1:0] line;
        int n, base;
        {i_req, d_req, d_wr, d_suc, m_aok_in, m_dok_in} = '0;
        {i_addr, d_addr, d_dout, d_size, d_wstrb} = '0;
        m_rdata = '0;
        m_busy = 1'b0;
        m_acc = 1'b0;
        m_own = 1'b0;
        m_cnt = 0;
        @(negedge clk);
        #1 zero_chk("reset");
        chk("reset_state", dut.state_q, 0);
        rst = 1'b0;
        step();
        step();

        // Icache alone: addrOK two cycles after req, dataOK five cycles after
        base = i_dok_n;
        i_req = 1'b1;
        i_addr = 32'h1C000040;
        step();
        #1 chk("t1_req_rises", {mem_req, mem_line, mem_size}, 4'b1110);
        step();
        m_aok_in = 1'b1;
        step();
        m_aok_in = 1'b0;
        i_req = 1'b0;
        step();
        step();
        m_dok_in = 1'b1;
        line = {4{32'hDEADBEEF}};
        m_rdata = line;
        #1 chk("t1_din", mem_icache_din, line);
        chk("t1_dcache_quiet", {mem_dcache_addrOK, mem_dcache_dataOK, mem_dcache_din}, '0);
        step();
        m_dok_in = 1'b0;
        step();
        chk("t1_one_pulse", i_dok_n - base, 1);

        // simultaneous requests: Dcache SUC write first, Icache after one arbitration bubble
        i_req = 1'b1;
        i_addr = 32'h1C000080;
        d_req = 1'b1;
        {d_wr, d_suc} = 2'b11;
        d_addr = 32'hBFD00010;
        d_dout = 32'hA5A5A5A5;
        d_size = 2'd2;
        d_wstrb = 4'b0011;
        step();
        #1 chk("t2_d_first", {mem_wr, mem_SUC, mem_line, mem_wdata, mem_wstrb}, {3'b110, 32'hA5A5A5A5, 4'b0011});
        m_aok_in = 1'b1;
        step();
        d_req = 1'b0;
        m_aok_in = 1'b0;
        m_dok_in = 1'b1;
        step();
        m_dok_in = 1'b0;
        #1 chk("t2_arb_idle", dut.state_q, 0);
        chk("t2_starve_one", dut.starve_q, 1);
        step();
        // Icache transaction served by zero-latency memory
        m_aok_in = 1'b1;
        m_dok_in = 1'b1;
        line = {32'h11112222, 32'h33334444, 32'h55556666, 32'h77778888};
        m_rdata = line;
        #1 chk("t2_i_granted", {mem_req, mem_line, mem_wr}, 3'b110);
        chk("t4_both_pulses", {mem_icache_addrOK, mem_icache_dataOK}, 2'b11);
        chk("t4_din", mem_icache_din, line);
        step();
        {i_req, m_aok_in, m_dok_in} = '0;
        #1 chk("t4_idle_next", dut.state_q, 0);
        chk("t2_starve_clear", dut.starve_q, 0);
        step();

        // Dcache hammers while Icache waits: D,D,D,D then I
        {d_wr, d_suc} = 2'b10;
        d_req = 1'b1;
        i_req = 1'b1;
        seq = '0;
        n = 0;
        for (int c = 0; c < 40 && n < 5; c++) begin
            m_aok_in = m_busy && !m_acc;
            m_dok_in = m_busy && !m_acc;
            #1;
            if (mem_req) begin
                seq = {seq[3:0], mem_wr};
                n++;
                if (n == 4) chk("t3_starve_four", dut.starve_q, 4);
                if (n == 5) chk("t3_starve_zero", dut.starve_q, 0);
            end
            step();
        end
        chk("t3_grant_count", n, 5);
        chk("t3_grant_order", seq, 5'b11110);
        {i_req, d_req, m_aok_in, m_dok_in} = '0;
        step();

        // Dcache flush in ADDR: back to IDLE, later dataOK never forwarded
        d_req = 1'b1;
        {d_wr, d_suc} = 2'b00;
        step();
        d_req = 1'b0;
        step();
        #1 chk("t5_idle", dut.state_q, 0);
        chk("t5_no_req", mem_req, 0);
        base = d_dok_n;
        m_dok_in = 1'b1;
        repeat (3) step();
        m_dok_in = 1'b0;
        chk("t5_no_dataok", d_dok_n - base, 0);

        // reset while in DATA discards the pending response
        d_req = 1'b1;
        step();
        m_aok_in = 1'b1;
        step();
        {m_aok_in, d_req} = '0;
        #1 chk("t6_in_data", dut.state_q, 2);
        base = d_dok_n;
        rst = 1'b1;
        #1 zero_chk("t6_reset");
        chk("t6_idle", dut.state_q, 0);
        m_dok_in = 1'b1;
        step();
        rst = 1'b0;
        step();
        m_dok_in = 1'b0;
        chk("t6_dropped", d_dok_n - base, 0);
        step();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if (i_req && (e_i_aok || $urandom_range(0, 63) == 0)) i_req = 1'b0;
            else if (!i_req && $urandom_range(0, 2) == 0) begin
                i_req = 1'b1;
                i_addr = $urandom & 32'hFFFF_FFF0;
            end
            if (d_req && (e_d_aok || $urandom_range(0, 63) == 0)) d_req = 1'b0;
            else if (!d_req && $urandom_range(0, 1) == 0) begin
                d_req = 1'b1;
                d_wr = 1'($urandom_range(0, 1));
                d_suc = 1'($urandom_range(0, 1));
                d_addr = $urandom;
                d_dout = $urandom;
                d_size = 2'($urandom_range(0, 2));
                d_wstrb = 4'($urandom);
            end
            rst = ($urandom_range(0, 399) == 0);
            m_aok_in = m_busy && !m_acc && $urandom_range(0, 2) == 0;
            m_dok_in = (m_busy && m_acc) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 5) == 0);
            m_rdata = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        rst = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
